// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Leading-zero blanking helper is used only when SEVSEG_LZB_EN is defined.
package sevseg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;
    localparam int MAX_DIGITS = 8;

    typedef logic [DIGIT_W-1:0]            digit_t;
    typedef logic [SEL_W-1:0]              sel_t;
    typedef logic [DIGIT_W*MAX_DIGITS-1:0] hexword_t;

    // Digit i (i>0) is a leading zero when every nibble from i up to the top digit is zero.
    function automatic logic lzb_f(input hexword_t val, input sel_t i, input int nd);
        logic upper_nz;
        upper_nz = 1'b0;
        for (int b = 0; b < DIGIT_W*MAX_DIGITS; b++) begin
            if ((b >= DIGIT_W*int'(i)) && (b < DIGIT_W*nd)) begin
                upper_nz = upper_nz | val[b];
            end else begin
                upper_nz = upper_nz;
            end
        end
        lzb_f = (i != 3'd0) && !upper_nz;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: free-running counter 0..TICK_DIV-1, tick on the last count.
module scan_prescaler
    import sevseg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc_r;

    assign tick = (presc_r == LAST_CNT);

    // Counter wraps on tick so each slot is exactly TICK_DIV cycles long.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {CW{1'b0}};
        end else if (tick) begin
            presc_r <= {CW{1'b0}};
        end else begin
            presc_r <= presc_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit hex scan controller with frame-synchronous loading.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [MAX_DIGITS-1:0] digit_en,
    output logic [DIGIT_W-1:0]    num,
    output logic [SEL_W-1:0]      sel,
    output logic                  blank,
    output logic                  frame_done
);

    localparam sel_t LAST_IDX = sel_t'(NUM_DIGITS - 1);

    logic     tick_s;
    logic     frame_wrap_s;
    logic     load_xfer_s;
    logic     lzb_s;
    logic     blank_s;
    digit_t   digit_s;
    sel_t     idx_r;
    logic     pending_r;
    hexword_t pend_data_r;
    hexword_t active_r;
    digit_t   num_r;
    sel_t     sel_r;
    logic     blank_r;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Handshake and frame-boundary decode; gated by rst so nothing leaks out during reset.
    always_comb begin
        frame_wrap_s = tick_s & (idx_r == LAST_IDX);
        load_xfer_s  = load_valid & ~pending_r & ~rst;
        load_ready   = ~pending_r & ~rst;
        frame_done   = frame_wrap_s & ~rst;
    end

    // Next-digit code and blanking for the slot currently indexed.
    always_comb begin
        digit_s = active_r[{idx_r, 2'b00} +: DIGIT_W];
`ifdef SEVSEG_LZB_EN
        lzb_s = lzb_f(active_r, idx_r, int'(NUM_DIGITS));
`else
        lzb_s = 1'b0;
`endif
        blank_s = ~digit_en[idx_r] | lzb_s;
    end

    // Digit index advances once per slot and wraps at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 3'd0;
        end else if (tick_s) begin
            idx_r <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // One-deep load buffer; the pending word becomes visible only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= 1'b0;
            pend_data_r <= 32'h0000_0000;
            active_r    <= 32'h0000_0000;
        end else if (frame_wrap_s && pending_r) begin
            pending_r   <= 1'b0;
            active_r    <= pend_data_r;
        end else if (load_xfer_s) begin
            pending_r   <= 1'b1;
            pend_data_r <= load_data;
        end else begin
            pending_r   <= pending_r;
        end
    end

    // Output registers trail idx/active by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r   <= 3'd0;
            num_r   <= 4'd0;
            blank_r <= 1'b0;
        end else begin
            sel_r   <= idx_r;
            num_r   <= digit_s;
            blank_r <= blank_s;
        end
    end

    assign sel   = sel_r;
    assign num   = num_r;
    assign blank = blank_r;

endmodule
